aes_word_io: RTL
================

Name: aes_word_io

Overview:
- 32-bit word-stream adapter wrapped around the AES_top core.
- Upstream side: collects 4 key words and 4 plaintext words from a valid/ready stream, presents them to the core as 128-bit AES_key_in/AES_data_in, and holds AES_en high until the core reports AES_data_out_valid.
- Downstream side: captures the 128-bit result and returns it as 4 words on a valid/ready stream.
- Feeds and consumes AES_top, so the core sees a stable, glitch-free enable/data protocol.

Parameters:
TIMEOUT_CYCLES, 64, max cycles core_en stays high awaiting core_out_valid (used only with AES_IO_TIMEOUT_EN)

Ports:
AES_clk  input  1  clock, rising edge
AES_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  block accepts input word this cycle
in_data  input  32  input word
out_valid  output  1  output word valid
out_ready  input  1  sink accepts output word
out_data  output  32  ciphertext word
out_last  output  1  high with 4th output word
core_en  output  1  to AES_top AES_en
core_key  output  128  to AES_top AES_key_in
core_data  output  128  to AES_top AES_data_in
core_out  input  128  from AES_top AES_data_out
core_out_valid  input  1  from AES_top AES_data_out_valid
busy  output  1  high in RUN or DRAIN
timeout_err  output  1  one-cycle pulse on timeout (0 unless AES_IO_TIMEOUT_EN)

Behaviour:
- Clock and reset: one clock, AES_clk. AES_rst_n is asynchronous, active-low; all flops clear immediately on assertion.
- Reset values:
  - state=LOAD, word counter=0
  - in_ready=1
  - out_valid=0, out_last=0, out_data=0
  - core_en=0, core_key=0, core_data=0
  - busy=0, timeout_err=0
- Word order: big-endian. First word of a group is bits [127:96], 4th is [31:0].
- LOAD:
  - in_ready=1. A word is accepted when in_valid & in_ready.
  - Accepted words 0-3 load core_key; words 4-7 load core_data. 3-bit counter.
  - When the 8th word is accepted in cycle N: go to RUN, core_en=1 from cycle N+1, counter wraps to 0.
  - core_key and core_data are stable for the whole of RUN.
- RUN:
  - in_ready=0, core_en=1, busy=1.
  - The first cycle core_out_valid=1 (sampled cycle M) captures core_out into the output shift register.
  - In M+1: core_en=0, state=DRAIN, out_valid=1, out_data=core_out[127:96].
  - core_out_valid is treated as a level or a pulse; only its first high cycle is used.
  - core_out_valid while not in RUN is ignored.
- DRAIN:
  - Word transfers when out_valid & out_ready. The next word is shown the following cycle.
  - out_data and out_last hold while out_ready=0.
  - out_last=1 on the 4th word. When that word transfers: out_valid=0, state=LOAD, busy=0, in_ready=1 next cycle.
  - in_ready=0 throughout DRAIN; no overlap of blocks.
- core_en is low for at least 8 cycles between blocks (LOAD length). This guarantees a fresh AES_en rising edge per block.
- Reset mid-operation: any state returns to LOAD and all partial words are discarded. core_en drops asynchronously with reset.
- No back-to-back key reuse: every block requires all 8 words.

Optional Feature:
AES_IO_TIMEOUT_EN
- Defined:
  - RUN counts cycles with core_en=1.
  - If TIMEOUT_CYCLES elapse without core_out_valid: core_en=0, timeout_err pulses for 1 cycle, state=LOAD, no output produced.
  - A valid arriving in the same cycle the count expires wins; the result is captured and no error pulses.
- Not defined: RUN waits indefinitely and timeout_err is tied 0.

Test Plan:
- FIPS-197 vector.
  - Stimulus: key words 00010203,04050607,08090a0b,0c0d0e0f, then data 00112233,44556677,8899aabb,ccddeeff, out_ready=1.
  - Required: core_key=000102..0f and core_data=0011..ff while core_en=1; out words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a; out_last on the 4th word; busy low afterwards.
- Backpressure: same vector, out_ready toggled 0/1 every 2 cycles. Required: each word held stable while out_ready=0; exactly 4 transfers; in_ready stays 0 until the last transfer.
- Input gaps: in_valid deasserted for 3 cycles between words 2 and 3, and between words 6 and 7. Required: core_en rises exactly 1 cycle after the 8th accept; same ciphertext as the FIPS-197 vector.
- Reset mid-RUN: assert AES_rst_n=0 for 1 cycle while core_en=1. Required: core_en=0 and in_ready=1 immediately; a following full vector encrypts correctly.
- Spurious core_out_valid: drive core_out_valid=1 during LOAD. Required: no out_valid; capture occurs only in RUN.
- With AES_IO_TIMEOUT_EN and TIMEOUT_CYCLES=16, core_out_valid held 0. Required: core_en high for exactly 16 cycles; timeout_err pulses once; in_ready=1 the next cycle; out_valid never asserted.

Source files
------------

// File: rtl/aes_word_io.sv
// 32-bit valid/ready word-stream adapter around the AES_top core: 8 words in, 4 words out.
// Optional AES_IO_TIMEOUT_EN aborts a RUN that waits more than TIMEOUT_CYCLES for the core.
module aes_word_io #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         core_en,
    output logic [127:0] core_key,
    output logic [127:0] core_data,
    input  logic [127:0] core_out,
    input  logic         core_out_valid,
    output logic         busy,
    output logic         timeout_err
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [2:0]     cnt_r, cnt_s;
    logic           in_ready_r, in_ready_s;
    logic           out_valid_r, out_valid_s;
    logic           out_last_r, out_last_s;
    logic [31:0]    out_data_r, out_data_s;
    logic [95:0]    out_sh_r, out_sh_s;
    logic           core_en_r, core_en_s;
    logic [127:0]   key_r, key_s;
    logic [127:0]   data_r, data_s;
    logic           busy_r, busy_s;

`ifdef AES_IO_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr_r, tmr_s;
    logic             timeout_err_r, timeout_err_s;
`endif

    // Next-state and next-output computation for every register of the block
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;
        out_last_s  = out_last_r;
        out_data_s  = out_data_r;
        out_sh_s    = out_sh_r;
        core_en_s   = core_en_r;
        key_s       = key_r;
        data_s      = data_r;
        busy_s      = busy_r;
`ifdef AES_IO_TIMEOUT_EN
        tmr_s         = tmr_r;
        timeout_err_s = 1'b0;
`endif
        case (state_r)
            ST_LOAD: begin
                if (in_valid && in_ready_r) begin
                    // Words shift in from the right so the first word lands in [127:96]
                    if (!cnt_r[2]) begin
                        key_s = {key_r[95:0], in_data};
                    end else begin
                        data_s = {data_r[95:0], in_data};
                    end
                    cnt_s = cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        state_s    = ST_RUN;
                        core_en_s  = 1'b1;
                        in_ready_s = 1'b0;
                        busy_s     = 1'b1;
`ifdef AES_IO_TIMEOUT_EN
                        tmr_s      = '0;
`endif
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (core_out_valid) begin
                    state_s     = ST_DRAIN;
                    core_en_s   = 1'b0;
                    out_valid_s = 1'b1;
                    out_last_s  = 1'b0;
                    out_data_s  = core_out[127:96];
                    out_sh_s    = core_out[95:0];
                    cnt_s       = 3'd0;
                end
`ifdef AES_IO_TIMEOUT_EN
                else if (tmr_r == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_s       = ST_LOAD;
                    core_en_s     = 1'b0;
                    in_ready_s    = 1'b1;
                    busy_s        = 1'b0;
                    cnt_s         = 3'd0;
                    timeout_err_s = 1'b1;
                end else begin
                    tmr_s = tmr_r + TMR_W'(1);
                end
`else
                else begin
                    state_s = ST_RUN;
                end
`endif
            end
            ST_DRAIN: begin
                if (out_valid_r && out_ready) begin
                    if (out_last_r) begin
                        state_s     = ST_LOAD;
                        out_valid_s = 1'b0;
                        out_last_s  = 1'b0;
                        in_ready_s  = 1'b1;
                        busy_s      = 1'b0;
                        cnt_s       = 3'd0;
                    end else begin
                        out_data_s = out_sh_r[95:64];
                        out_sh_s   = {out_sh_r[63:0], 32'd0};
                        cnt_s      = cnt_r + 3'd1;
                        out_last_s = (cnt_r == 3'd2);
                    end
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s     = ST_LOAD;
                cnt_s       = 3'd0;
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                out_last_s  = 1'b0;
                core_en_s   = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops core_en and discards partial words
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state_r     <= ST_LOAD;
            cnt_r       <= 3'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= 32'd0;
            out_sh_r    <= 96'd0;
            core_en_r   <= 1'b0;
            key_r       <= 128'd0;
            data_r      <= 128'd0;
            busy_r      <= 1'b0;
`ifdef AES_IO_TIMEOUT_EN
            tmr_r         <= '0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_last_r  <= out_last_s;
            out_data_r  <= out_data_s;
            out_sh_r    <= out_sh_s;
            core_en_r   <= core_en_s;
            key_r       <= key_s;
            data_r      <= data_s;
            busy_r      <= busy_s;
`ifdef AES_IO_TIMEOUT_EN
            tmr_r         <= tmr_s;
            timeout_err_r <= timeout_err_s;
`endif
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;
    assign core_en   = core_en_r;
    assign core_key  = key_r;
    assign core_data = data_r;
    assign busy      = busy_r;
`ifdef AES_IO_TIMEOUT_EN
    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
